// File: rtl/rc4_state_mem_pkg.sv
// Shared definitions for the RC4 state memory: FSM encoding and default geometry.
package rc4_state_mem_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    typedef logic [0:0] state_t;

    localparam state_t ST_FILL  = 1'b0;
    localparam state_t ST_READY = 1'b1;

endpackage

// File: rtl/rc4_state_array.sv
// Storage for the RC4 permutation: fill, swap and single-write paths, two combinational reads.
module rc4_state_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              fill_we,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              swap_we,
    input  logic [ADDR_W-1:0] swap_a,
    input  logic [ADDR_W-1:0] swap_b,
    input  logic              wr_we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] raddr_1,
    output logic [DATA_W-1:0] rdata_1,
    input  logic [ADDR_W-1:0] raddr_3,
    output logic [DATA_W-1:0] rdata_3
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Enables are mutually exclusive by construction in the controller; the
    // if/else chain only documents the precedence it already guarantees.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            mem_q[fill_addr] <= fill_data;
        end else if (swap_we) begin
            mem_q[swap_a] <= mem_q[swap_b];
            mem_q[swap_b] <= mem_q[swap_a];
        end else if (wr_we) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rdata_1 = mem_q[raddr_1];
    assign rdata_3 = mem_q[raddr_3];

endmodule

// File: rtl/rc4_state_mem.sv
// RC4 state memory: identity fill FSM plus arbitrated swap / write-port access.
module rc4_state_mem
    import rc4_state_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_req,
    output logic              ready,
    input  logic [ADDR_W-1:0] raddr_1,
    output logic [DATA_W-1:0] rdata_1,
    input  logic              wen_2,
    input  logic [ADDR_W-1:0] waddr_2,
    input  logic [DATA_W-1:0] wdata_2,
    input  logic              wen_3,
    input  logic [ADDR_W-1:0] addr_3,
    input  logic [DATA_W-1:0] wdata_3,
    output logic [DATA_W-1:0] rdata_3,
    input  logic              swap_req,
    input  logic [ADDR_W-1:0] swap_a,
    input  logic [ADDR_W-1:0] swap_b,
    output logic              blocked,
    output logic [0:0]        dbg_state
);

    // Request interface: every request is a single-cycle level sampled on the
    // rising edge; there is no back-pressure beyond ready, and a request that
    // is not executed is dropped and reported through blocked on the next cycle.

    localparam logic [ADDR_W-1:0] CNT_LAST = '1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              blocked_q, blocked_d;

    logic              fill_we, swap_we, wr_we;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] fill_data;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        blocked_d = 1'b0;
        fill_we   = 1'b0;
        swap_we   = 1'b0;
        wr_we     = 1'b0;
        wr_addr   = waddr_2;
        wr_data   = wdata_2;
        if (state_q == ST_FILL) begin
            fill_we   = 1'b1;
            blocked_d = swap_req | wen_2 | wen_3;
            if (init_req) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_READY;
                end
            end
        end else if (init_req) begin
            state_d   = ST_FILL;
            cnt_d     = '0;
            blocked_d = swap_req | wen_2 | wen_3;
        end else if (swap_req) begin
            // A self-swap is a legal no-op, not a dropped request.
            swap_we   = (swap_a != swap_b);
            blocked_d = wen_2 | wen_3;
        end else if (wen_2) begin
            wr_we     = 1'b1;
            blocked_d = wen_3;
        end else if (wen_3) begin
            wr_we   = 1'b1;
            wr_addr = addr_3;
            wr_data = wdata_3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FILL;
            cnt_q     <= '0;
            blocked_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            blocked_q <= blocked_d;
        end
    end

    assign fill_data = DATA_W'(cnt_q);
    assign ready     = (state_q == ST_READY);
    assign blocked   = blocked_q;
    assign dbg_state = state_q;

    // Gating with rst_n keeps the array untouched by any edge seen during reset.
    rc4_state_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk       (clk),
        .fill_we   (fill_we & rst_n),
        .fill_addr (cnt_q),
        .fill_data (fill_data),
        .swap_we   (swap_we & rst_n),
        .swap_a    (swap_a),
        .swap_b    (swap_b),
        .wr_we     (wr_we & rst_n),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .raddr_1   (raddr_1),
        .rdata_1   (rdata_1),
        .raddr_3   (addr_3),
        .rdata_3   (rdata_3)
    );

endmodule

// File: tb/tb_rc4_state_mem.sv
// Randomised bench for rc4_state_mem against an array-level reference model.
module tb_rc4_state_mem;

    logic       clk;
    logic       rst_n;
    logic       init_req;
    logic       ready;
    logic [7:0] raddr_1;
    logic [7:0] rdata_1;
    logic       wen_2;
    logic [7:0] waddr_2;
    logic [7:0] wdata_2;
    logic       wen_3;
    logic [7:0] addr_3;
    logic [7:0] wdata_3;
    logic [7:0] rdata_3;
    logic       swap_req;
    logic [7:0] swap_a;
    logic [7:0] swap_b;
    logic       blocked;
    logic [0:0] dbg_state;

    logic       s_init_req;
    logic       s_ready;
    logic [3:0] s_raddr_1;
    logic [2:0] s_rdata_1;
    logic       s_wen_2;
    logic [3:0] s_waddr_2;
    logic [2:0] s_wdata_2;
    logic       s_wen_3;
    logic [3:0] s_addr_3;
    logic [2:0] s_wdata_3;
    logic [2:0] s_rdata_3;
    logic       s_swap_req;
    logic [3:0] s_swap_a;
    logic [3:0] s_swap_b;
    logic       s_blocked;
    logic [0:0] s_dbg_state;

    int         n_chk;
    int         n_fail;
    logic [7:0] model [256];
    logic [7:0] exp_q [$];

    rc4_state_mem dut (
        .clk(clk), .rst_n(rst_n), .init_req(init_req), .ready(ready),
        .raddr_1(raddr_1), .rdata_1(rdata_1),
        .wen_2(wen_2), .waddr_2(waddr_2), .wdata_2(wdata_2),
        .wen_3(wen_3), .addr_3(addr_3), .wdata_3(wdata_3), .rdata_3(rdata_3),
        .swap_req(swap_req), .swap_a(swap_a), .swap_b(swap_b),
        .blocked(blocked), .dbg_state(dbg_state)
    );

    rc4_state_mem #(.ADDR_W(4), .DATA_W(3)) dut_small (
        .clk(clk), .rst_n(rst_n), .init_req(s_init_req), .ready(s_ready),
        .raddr_1(s_raddr_1), .rdata_1(s_rdata_1),
        .wen_2(s_wen_2), .waddr_2(s_waddr_2), .wdata_2(s_wdata_2),
        .wen_3(s_wen_3), .addr_3(s_addr_3), .wdata_3(s_wdata_3), .rdata_3(s_rdata_3),
        .swap_req(s_swap_req), .swap_a(s_swap_a), .swap_b(s_swap_b),
        .blocked(s_blocked), .dbg_state(s_dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        init_req = 1'b0;
        wen_2 = 1'b0; waddr_2 = '0; wdata_2 = '0;
        wen_3 = 1'b0; addr_3 = '0; wdata_3 = '0;
        swap_req = 1'b0; swap_a = '0; swap_b = '0;
    endtask

    task automatic model_identity();
        for (int i = 0; i < 256; i++) model[i] = 8'(i);
    endtask

    // Reference semantics: one winner per edge, everything else asserted is dropped.
    task automatic drive_op(input logic sw, input logic [7:0] sa, input logic [7:0] sb,
                            input logic w2, input logic [7:0] a2, input logic [7:0] d2,
                            input logic w3, input logic [7:0] a3, input logic [7:0] d3);
        logic [7:0] t;
        logic       bl;
        swap_req = sw; swap_a = sa; swap_b = sb;
        wen_2 = w2; waddr_2 = a2; wdata_2 = d2;
        wen_3 = w3; addr_3 = a3; wdata_3 = d3;
        if (sw) begin
            t = model[sa];
            model[sa] = model[sb];
            model[sb] = t;
            bl = w2 | w3;
        end else if (w2) begin
            model[a2] = d2;
            bl = w3;
        end else begin
            if (w3) model[a3] = d3;
            bl = 1'b0;
        end
        exp_q.push_back({7'b0, bl});
        @(posedge clk);
        #1;
        idle_inputs();
        chk("op_blocked", {31'b0, blocked}, {24'b0, exp_q.pop_front()});
    endtask

    task automatic rd1(input string tag, input logic [7:0] a);
        raddr_1 = a;
        #1;
        chk(tag, {24'b0, rdata_1}, {24'b0, model[a]});
    endtask

    task automatic rd3(input string tag, input logic [7:0] a);
        addr_3 = a;
        #1;
        chk(tag, {24'b0, rdata_3}, {24'b0, model[a]});
    endtask

    task automatic scan_all(input string tag);
        @(negedge clk);
        for (int i = 0; i < 256; i++) rd1(tag, 8'(i));
    endtask

    // Counts edges until ready; random dropped requests are injected and checked
    // each cycle, and an optional restart via init_req is issued at restart_at.
    task automatic wait_fill(input string tag, input bit with_reqs, input int restart_at);
        int  n;
        int  guard;
        bit  restarted;
        logic bl;
        n = 0; guard = 0; restarted = 0;
        while (!ready && guard < 2000) begin
            bl = 1'b0;
            if (with_reqs) begin
                swap_req = ($urandom_range(0, 3) == 0);
                wen_2    = ($urandom_range(0, 3) == 0);
                wen_3    = ($urandom_range(0, 3) == 0);
                swap_a = 8'($urandom); swap_b = 8'($urandom);
                waddr_2 = 8'($urandom); wdata_2 = 8'($urandom);
                addr_3 = 8'($urandom); wdata_3 = 8'($urandom);
                bl = swap_req | wen_2 | wen_3;
            end
            if (restart_at >= 0 && n == restart_at && !restarted) init_req = 1'b1;
            @(posedge clk);
            #1;
            guard++;
            if (init_req) begin
                n = 0;
                restarted = 1;
            end else begin
                n++;
            end
            idle_inputs();
            if (with_reqs) chk({tag, "_blocked"}, {31'b0, blocked}, {31'b0, bl});
        end
        chk({tag, "_len"}, n, 256);
        if (restart_at >= 0) chk({tag, "_restarted"}, {31'b0, restarted}, 32'd1);
        chk({tag, "_state"}, {31'b0, dbg_state}, 32'd1);
        model_identity();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        int sn;
        logic [7:0] a;
        logic [7:0] b;
        n_chk = 0;
        n_fail = 0;
        idle_inputs();
        raddr_1 = '0;
        s_init_req = 1'b0; s_raddr_1 = '0;
        s_wen_2 = 1'b0; s_waddr_2 = '0; s_wdata_2 = '0;
        s_wen_3 = 1'b0; s_addr_3 = '0; s_wdata_3 = '0;
        s_swap_req = 1'b0; s_swap_a = '0; s_swap_b = '0;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, ready}, 32'd0);
        chk("rst_blocked", {31'b0, blocked}, 32'd0);
        chk("rst_state", {31'b0, dbg_state}, 32'd0);
        chk("rst_s_ready", {31'b0, s_ready}, 32'd0);

        // Initial fill: both instances start on the same edge.
        @(negedge clk);
        rst_n = 1'b1;
        n = 0; sn = 0;
        while (!ready && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
            if (s_ready && sn == 0) sn = n;
        end
        chk("fill_len", n, 256);
        chk("small_fill_len", sn, 16);
        model_identity();
        rd1("rd_00", 8'h00);
        rd1("rd_7f", 8'h7F);
        rd1("rd_ff", 8'hFF);
        scan_all("init_scan");

        for (int i = 0; i < 16; i++) begin
            s_raddr_1 = 4'(i);
            #1;
            chk("small_scan", {29'b0, s_rdata_1}, i % 8);
        end
        s_raddr_1 = 4'd13;
        #1;
        chk("small_13", {29'b0, s_rdata_1}, 32'd5);

        // Directed cases.
        drive_op(1'b1, 8'h03, 8'hC8, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
        rd1("swap_03", 8'h03);
        chk("swap_03_abs", {24'b0, rdata_1}, 32'hC8);
        rd1("swap_c8", 8'hC8);
        chk("swap_c8_abs", {24'b0, rdata_1}, 32'h03);

        drive_op(1'b1, 8'h10, 8'h20, 1'b1, 8'h30, 8'hAA, 1'b1, 8'h40, 8'h55);
        chk("prio_blocked", {31'b0, blocked}, 32'd1);
        rd1("prio_10", 8'h10);
        rd1("prio_20", 8'h20);
        rd1("prio_30", 8'h30);
        chk("prio_30_abs", {24'b0, rdata_1}, 32'h30);
        rd3("prio_40", 8'h40);
        chk("prio_40_abs", {24'b0, rdata_3}, 32'h40);
        @(posedge clk);
        #1;
        chk("blocked_pulse_end", {31'b0, blocked}, 32'd0);

        drive_op(1'b0, 8'h00, 8'h00, 1'b1, 8'h05, 8'h99, 1'b1, 8'h05, 8'h11);
        chk("w2_over_w3_blocked", {31'b0, blocked}, 32'd1);
        rd1("w2_over_w3", 8'h05);
        chk("w2_over_w3_abs", {24'b0, rdata_1}, 32'h99);

        drive_op(1'b1, 8'h77, 8'h77, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
        chk("self_swap_blocked", {31'b0, blocked}, 32'd0);
        rd1("self_swap", 8'h77);

        drive_op(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 8'h9A, 8'h3C);
        rd3("w3_only", 8'h9A);

        // Randomised operation mix.
        for (int i = 0; i < 300; i++) begin
            a = 8'($urandom);
            b = ($urandom_range(0, 7) == 0) ? a : 8'($urandom);
            drive_op(($urandom_range(0, 2) == 0), a, b,
                     ($urandom_range(0, 1) == 1), 8'($urandom), 8'($urandom),
                     ($urandom_range(0, 1) == 1), 8'($urandom), 8'($urandom));
            rd1("rand_rd1", a);
            rd3("rand_rd3", b);
        end
        scan_all("rand_scan");

        // Re-init from READY with dropped requests and a restart mid-fill.
        init_req = 1'b1;
        @(posedge clk);
        #1;
        idle_inputs();
        chk("init_blocked", {31'b0, blocked}, 32'd0);
        chk("init_ready", {31'b0, ready}, 32'd0);
        wait_fill("refill", 1'b1, 50);
        scan_all("refill_scan");

        // Dirty memory, start a fill, then reset at count 100.
        for (int i = 0; i < 40; i++) begin
            drive_op(1'b0, 8'h00, 8'h00, 1'b1, 8'($urandom), 8'($urandom), 1'b0, 8'h00, 8'h00);
        end
        init_req = 1'b1;
        @(posedge clk);
        #1;
        idle_inputs();
        repeat (100) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midfill_rst_ready", {31'b0, ready}, 32'd0);
        chk("midfill_rst_blocked", {31'b0, blocked}, 32'd0);
        chk("midfill_rst_state", {31'b0, dbg_state}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_fill("rst_refill", 1'b0, -1);
        scan_all("rst_refill_scan");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rc4_state_mem.md
RC4_STATE_MEM -- requirements
Module: rc4_state_mem

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning address width; DEPTH = 2**ADDR_W entries.
REQ-002 SHALL have parameter DATA_W, default 8, meaning entry width.
REQ-003 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port init_req  in  1  single-cycle request to re-run identity fill.
REQ-006 SHALL have port ready  out  1  high when fill complete and requests are accepted.
REQ-007 SHALL have ports raddr_1 in ADDR_W and rdata_1 out DATA_W: combinational read port 1.
REQ-008 SHALL have ports wen_2 in 1, waddr_2 in ADDR_W, wdata_2 in DATA_W: write port 2.
REQ-009 SHALL have ports wen_3 in 1, addr_3 in ADDR_W, wdata_3 in DATA_W, rdata_3 out DATA_W: read/write port 3, combinational read.
REQ-010 SHALL have ports swap_req in 1, swap_a in ADDR_W, swap_b in ADDR_W: atomic two-entry swap.
REQ-011 SHALL have port blocked  out  1  one-cycle pulse when any asserted request was not executed.

Function
REQ-012 SHALL implement FSM states FILL and READY; ready = (state == READY).
REQ-013 In FILL SHALL write mem[k] = k (truncated or zero-extended to DATA_W) at k = fill counter, counter increments by 1 per cycle.
REQ-014 SHALL leave FILL for READY on the edge that writes k = DEPTH-1; fill therefore takes exactly DEPTH cycles, ready high from the following cycle.
REQ-015 init_req sampled high in READY SHALL move to FILL with counter = 0 on the same edge; init_req in FILL SHALL restart counter at 0.
REQ-016 In FILL, wen_2, wen_3 and swap_req SHALL be ignored and each asserted one SHALL raise blocked for that cycle.
REQ-017 In READY, priority SHALL be swap_req > wen_2 > wen_3; exactly one operation executes per edge, lower asserted requests raise blocked.
REQ-018 Swap SHALL write mem[swap_a] <= old mem[swap_b] and mem[swap_b] <= old mem[swap_a] on one edge; swap_a == swap_b SHALL leave memory unchanged and not raise blocked.
REQ-019 wen_2 SHALL write mem[waddr_2] <= wdata_2; wen_3 SHALL write mem[addr_3] <= wdata_3.
REQ-020 rdata_1 and rdata_3 SHALL reflect current memory contents combinationally (write visible the cycle after the edge); values are undefined while ready = 0.
REQ-021 Addresses SHALL wrap naturally modulo DEPTH; no out-of-range case exists.

Reset
REQ-022 rst_n low SHALL asynchronously force state = FILL, fill counter = 0, blocked = 0, ready = 0.
REQ-023 Memory array SHALL NOT be reset; contents are defined only by fill and later writes.
REQ-024 rst_n asserted mid-fill or mid-operation SHALL abort it; fill restarts from 0 after release, no partial write occurs on the reset edge.

Structure
REQ-025 Shared package SHALL hold the FSM state encoding (FILL, READY) and the default ADDR_W/DATA_W constants.
REQ-026 Storage array SHALL be a sub-module rc4_state_array (three write-enable decode paths, two combinational reads); control FSM, counter and priority logic stay in rc4_state_mem.

Verification
REQ-027 Release rst_n, hold all requests low -> ready rises after exactly 256 clk edges; rdata_1 at raddr_1 = 0x00, 0x7F, 0xFF reads 0x00, 0x7F, 0xFF.
REQ-028 In READY, swap_req with swap_a = 0x03, swap_b = 0xC8 -> next cycle mem[0x03] = 0xC8, mem[0xC8] = 0x03, blocked = 0.
REQ-029 Same cycle swap_req (0x10, 0x20), wen_2 (0x30, 0xAA), wen_3 (0x40, 0x55) -> only swap executes, mem[0x30] = 0x30, mem[0x40] = 0x40, blocked pulses 1 cycle.
REQ-030 wen_2 at 0x05 = 0x99 with wen_3 at 0x05 = 0x11 -> mem[0x05] = 0x99, blocked = 1.
REQ-031 Assert rst_n low at fill count 100, release, and separately init_req in READY after writes -> ready low for exactly 256 cycles, all entries identity afterwards, requests during fill raise blocked.
REQ-032 ADDR_W = 4, DATA_W = 3 instance -> fill takes 16 cycles, mem[13] = 5 (13 truncated to 3 bits).
